// File: rtl/mux_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the
// multiplexed round-robin arbiter and any sibling arbiters.
package mux_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  localparam int               STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  // Widest requester vector the picker supports, and the index width for it.
  localparam int PICK_MAX   = 8;
  localparam int PICK_IDX_W = 3;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // Searches ptr+1, ptr+2, ... modulo n and returns the first valid index.
  // Searching n steps ends back at ptr itself, so a lone requester at ptr wins.
  function automatic pick_t rr_pick(input logic [PICK_MAX-1:0]   valid,
                                    input logic [PICK_IDX_W-1:0] ptr,
                                    input int                    n);
    pick_t res;
    int    cand;
    res = '0;
    for (int k = 1; k <= PICK_MAX; k++) begin
      cand = (int'(ptr) + k) % n;
      if (k <= n && !res.found && valid[cand[PICK_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[PICK_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational round-robin picker: one-hot grant plus binary index of the
// first valid requester after ptr.
module rr_pick_onehot
  import mux_arb_pkg::*;
#(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  pick_t res;

  always_comb begin
    res   = rr_pick(PICK_MAX'(valid), PICK_IDX_W'(ptr), N);
    found = res.found;
    idx   = IDX_W'(res.idx);
    grant = res.found ? (N'(1) << res.idx) : '0;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with locked bursts feeding a registered valid/ready
// output stage. Define MUX_RR_ARBITER_STATS_EN for per-requester grant counters.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ   = 6,
  parameter int DATA_W    = 4,
  parameter int SEL_W     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready,
  output logic                      busy,
  input  logic [SEL_W-1:0]          stat_idx,
  output logic [STAT_W-1:0]         stat_cnt
);

  localparam int BEAT_W = 4;

  arb_state_e          state_q, state_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]    owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;

  logic [NUM_REQ-1:0]  owner_oh, pick_valid, pick_grant;
  logic [SEL_W-1:0]    pick_idx;
  logic                pick_found;
  logic                can_load, xfer, xfer_lock;
  logic [DATA_W-1:0]   sel_data;

  // In BURST only the owner is offered to the picker; rr_ptr equals the owner
  // there, and the full-circle search lands back on it.
  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign pick_valid = (state_q == ARB_BURST) ? (req_valid & owner_oh) : req_valid;

  rr_pick_onehot #(
    .N     (NUM_REQ),
    .IDX_W (SEL_W)
  ) u_pick (
    .valid (pick_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign can_load  = !out_valid_q || out_ready;
  assign req_ready = (rst_n && can_load && pick_found) ? pick_grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign xfer_lock = |(req_lock & req_ready);

  // Select datapath: codes at or above NUM_REQ fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == SEL_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = pick_idx;
      rr_ptr_d    = pick_idx;
      unique case (state_q)
        ARB_IDLE: begin
          if (xfer_lock && MAX_BURST > 1) begin
            state_d    = ARB_BURST;
            owner_d    = pick_idx;
            beat_cnt_d = BEAT_W'(1);
          end
        end
        ARB_BURST: begin
          if (!xfer_lock || (beat_cnt_q + BEAT_W'(1)) == BEAT_W'(MAX_BURST)) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= SEL_W'(NUM_REQ - 1);
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign busy      = (state_q == ARB_BURST);

`ifdef MUX_RR_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];
  logic [STAT_W-1:0] stat_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (req_valid[i] && req_ready[i] && stat_q[i] != STAT_MAX) begin
        stat_d[i] = stat_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is plain flops, not a RAM, so it is cleared through reset like any other state.
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= stat_d[i];
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stat_idx == SEL_W'(i)) stat_cnt = stat_q[i];
    end
  end
`else
  logic stat_idx_unused;
  assign stat_idx_unused = ^stat_idx;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomised scoreboard bench for mux_rr_arbiter: a behavioural model predicts
// each accepted beat, and a negedge monitor compares beats as they drain.
module tb_mux_rr_arbiter;

  localparam int N  = 6;
  localparam int DW = 4;
  localparam int SW = 3;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_lock = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_sel;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [SW-1:0]     stat_idx = '0;
  logic [15:0]       stat_cnt;

  always #10 clk = ~clk;

  mux_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .SEL_W     (SW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .busy      (busy),
    .stat_idx  (stat_idx),
    .stat_cnt  (stat_cnt)
  );

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    seen_sel[$];
  beat_t mon_exp;
  int    n_checks = 0;
  int    n_fail   = 0;

  // Behavioural model: who owns the arbiter, where the search starts, and
  // whether the output register holds a beat after the coming edge.
  int m_ptr;
  bit m_burst;
  int m_owner;
  int m_beats;
  bit m_out_valid;
  int m_stat[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v);
    if (m_burst) return v[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int exp_stat(input int i);
`ifdef MUX_RR_ARBITER_STATS_EN
    return (i < N) ? m_stat[i] : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    return (N*DW)'($urandom());
  endfunction

  // Scoreboard monitor: each beat is seen exactly once, on the negedge
  // before the edge where it drains.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got sel %0d data %0h, expected no beat", out_sel, out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_sel", 32'(out_sel), 32'(mon_exp.sel));
        check("out_data", 32'(out_data), 32'(mon_exp.data));
      end
      seen_sel.push_back(int'(out_sel));
    end
  end

  // One cycle of stimulus: inputs settle 1 time unit after posedge and are
  // sampled by the DUT at the following posedge.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [N*DW-1:0] d, input logic r);
    int           w;
    bit           can_load;
    logic [N-1:0] exp_ready;
    beat_t        b;
    @(posedge clk);
    #1;
    req_valid = v;
    req_lock  = l;
    req_data  = d;
    out_ready = r;
    #1;
    can_load  = !m_out_valid || r;
    w         = model_winner(v);
    exp_ready = '0;
    if (can_load && w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_burst));
    if (can_load && w >= 0) begin
      b.sel  = SW'(w);
      b.data = d[w*DW +: DW];
      exp_q.push_back(b);
      m_out_valid = 1'b1;
      m_ptr       = w;
      if (m_stat[w] < 65535) m_stat[w]++;
      if (!m_burst) begin
        if (l[w] && MB > 1) begin
          m_burst = 1'b1;
          m_owner = w;
          m_beats = 1;
        end
      end else begin
        m_beats++;
        if (!l[w] || m_beats == MB) m_burst = 1'b0;
      end
    end else if (r) begin
      m_out_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, rand_data(), 1'b1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_stats();
    for (int i = 0; i < 8; i++) begin
      stat_idx = SW'(i);
      #1;
      check("stat_cnt", 32'(stat_cnt), 32'(exp_stat(i)));
    end
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_len"}, 32'(seen_sel.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen_sel.size(); i++) begin
      check(name, 32'(seen_sel[i]), 32'(exp[i]));
    end
    seen_sel.delete();
  endtask

  // Asserts reset immediately, checks the cleared outputs, and releases it
  // just after a negedge with no requester valid.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    m_ptr       = N - 1;
    m_burst     = 1'b0;
    m_owner     = 0;
    m_beats     = 0;
    m_out_valid = 1'b0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
    exp_q.delete();
    seen_sel.delete();
    check_stats();
    req_valid = '0;
    req_lock  = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N*DW-1:0] d;

    #3;
    do_reset();

    // Full-rate rotation from reset: 0,1,2,3,4,5,0.
    repeat (7) drive('1, '0, rand_data(), 1'b1);
    idle(2);
    check_seq("rotate_seq", '{0, 1, 2, 3, 4, 5, 0});

    // Lone requester 3 held off by back-pressure: a single transfer, stable output.
    d = rand_data();
    d[3*DW +: DW] = 4'hA;
    drive(6'b001000, '0, d, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(6'b001000, '0, d, 1'b0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_sel", 32'(out_sel), 32'd3);
      check("hold_out_data", 32'(out_data), 32'hA);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    idle(2);
    check_seq("hold_seq", '{3});

    // Locked burst from 2 capped at MAX_BURST, then 4 gets its turn, then 2.
    drive(6'b000100, 6'b000100, rand_data(), 1'b1);
    repeat (5) drive(6'b010100, 6'b000100, rand_data(), 1'b1);
    drive(6'b000100, '0, rand_data(), 1'b1);
    idle(2);
    check_seq("burst_seq", '{2, 2, 2, 2, 4, 2, 2});

    // Owner 1 stalls mid-burst; 5 must wait until the burst completes.
    drive(6'b000010, 6'b000010, rand_data(), 1'b1);
    drive(6'b100010, 6'b000010, rand_data(), 1'b1);
    repeat (2) begin
      drive(6'b100000, 6'b000010, rand_data(), 1'b1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    repeat (3) drive(6'b100010, 6'b000010, rand_data(), 1'b1);
    idle(2);
    check_seq("stall_seq", '{1, 1, 1, 1, 5});
    check_stats();

    // Reset in the middle of a burst with a beat held.
    drive(6'b000100, 6'b000100, rand_data(), 1'b1);
    drive(6'b000100, 6'b000100, rand_data(), 1'b1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    do_reset();
    repeat (2) drive('1, '0, rand_data(), 1'b1);
    idle(2);
    check_seq("post_rst_seq", '{0, 1});

`ifdef MUX_RR_ARBITER_STATS_EN
    // Saturate requester 5's counter.
    repeat (70000) drive(6'b100000, '0, rand_data(), 1'b1);
    idle(2);
    stat_idx = 3'd5;
    #1;
    check("stat_sat", 32'(stat_cnt), 32'hFFFF);
    stat_idx = 3'd7;
    #1;
    check("stat_oob", 32'(stat_cnt), 32'd0);
`endif
    check_stats();

    // Randomised traffic with occasional locks and back-pressure.
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom()), N'($urandom() & $urandom()), rand_data(), ($urandom_range(0, 3) != 0));
    end
    idle(3);
    check_stats();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one 6:1 × 4-bit select datapath among NUM_REQ requesters, using round-robin arbitration with optional locked bursts.
- Drives the select code and captures the selected word into a registered output stage with a valid/ready handshake.
- Sits between the requester ports and the downstream consumer, replacing any free-running select driver.

Parameters:
- NUM_REQ, 6, number of requesters; legal range 2..8.
- DATA_W, 4, data width per requester.
- SEL_W, 3, select code width; must satisfy 2**SEL_W >= NUM_REQ.
- MAX_BURST, 4, maximum beats per locked burst; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_lock  in  NUM_REQ  per-requester burst lock, sampled with the accepted beat.
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot-or-zero grant/accept.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered selected data.
- out_sel  out  SEL_W  registered index of the requester that supplied out_data.
- out_ready  in  1  downstream accept.
- busy  out  1  high while the FSM is in BURST.
- stat_idx  in  SEL_W  statistics read index.
- stat_cnt  out  16  statistics read data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0, busy=0; req_ready is 0 while in reset.
  - state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), beat_cnt=0.
- Accept condition: can_load = !out_valid || out_ready. Full throughput is one beat per cycle.
- req_ready is combinational:
  - It is zero when can_load=0.
  - Otherwise it is one-hot on the winner of the current state.
- Transfer: a beat transfers when req_valid[w] && req_ready[w]. On that edge:
  - out_data <= data of w, out_sel <= w, out_valid <= 1.
- If out_ready=1 and no transfer occurs, out_valid <= 0.
- The select code always equals the requester index. Codes >= NUM_REQ are never produced; the internal mux default for them is 0.
- FSM state IDLE:
  - Winner is the first valid requester searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_REQ.
  - On transfer, rr_ptr <= w.
  - If req_lock[w]=1 and MAX_BURST>1: state <= BURST, owner <= w, beat_cnt <= 1.
- FSM state BURST:
  - Only the owner is eligible and other requesters see req_ready=0.
  - If the owner's valid is low, the block stalls in BURST with no grants.
  - On each owner transfer, beat_cnt increments.
  - Exit to IDLE on the edge where a transfer has req_lock=0 or beat_cnt+1 == MAX_BURST.
  - rr_ptr stays at the owner, so the next IDLE arbitration starts after the owner.
- busy = (state==BURST).
- Simultaneous events: a new load and a drain in the same cycle keeps out_valid=1 with the new data. There is no bubble.
- out_valid=1 && out_ready=0: out_data and out_sel hold stable and every req_ready is 0.
- Mid-operation reset: any burst is abandoned and the held beat is discarded. The first grant after reset goes to requester 0 if it is valid.

Optional Feature:
- Macro: MUX_RR_ARBITER_STATS_EN.
- Defined:
  - One 16-bit saturating grant counter per requester, incremented on each transfer from that requester; it holds at 16'hFFFF.
  - Counters are cleared by reset.
  - stat_cnt = counter[stat_idx] combinationally; stat_cnt=0 when stat_idx >= NUM_REQ.
- Undefined: no counters are instantiated and stat_cnt is tied to 0. The port list is identical in both builds.

Decomposition:
- Package mux_arb_pkg holds:
  - the state enum {ARB_IDLE, ARB_BURST};
  - constants STAT_W=16 and STAT_MAX=16'hFFFF;
  - a function rr_pick(valid, ptr) returning the winner index plus a found flag.
- One sub-module, rr_pick_onehot: a combinational round-robin picker taking valid and ptr and returning a one-hot grant and a binary index. It is reusable by other arbiters.
- The FSM, output register and statistics stay in the top module.

Test Plan:
- After reset, req_valid=6'b111111, lock=0, out_ready=1 -> out_sel sequence 0,1,2,3,4,5,0 on consecutive cycles; out_data equals each requester's data.
- Only requester 3 valid with data 4'hA, out_ready=0 for 3 cycles -> out_valid=1, out_data=A, out_sel=3 held stable; req_ready=0 throughout; one transfer only.
- Requester 2 with lock=1 for 6 beats, requester 4 also valid, MAX_BURST=4 -> four consecutive beats from 2 with busy=1, then requester 4 granted, then 2 again.
- In BURST, owner 1 drops valid for 2 cycles while 5 is valid -> no grant to 5 during the stall; burst resumes when 1 reasserts.
- rst_n pulsed low mid-burst while out_valid=1 -> outputs go to 0 immediately; the first post-reset grant goes to requester 0 when it is valid.
- With MUX_RR_ARBITER_STATS_EN: 70000 beats from requester 5 -> stat_idx=5 reads 16'hFFFF; stat_idx=7 reads 0. Without the macro, stat_cnt is 0 always.
